// File: rtl/ctc_int_ctrl.sv
// ctc_int_ctrl: interrupt controller for a 4-channel Z80 CTC.
// Edge-captures each channel's zero-count/timeout and arbitrates pending
// requests by fixed priority (channel 0 highest). It takes part in the
// IEI/IEO daisy chain and drives the mode-2 vector during acknowledge.
// It also watches opcode fetches for RETI (ED 4D) to retire the in-service channel.
module ctc_int_ctrl #(
  parameter int DWID = 8,
  parameter int NCH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  zc_to,
  input  logic [NCH-1:0]  int_en,
  input  logic            vec_wstb,
  input  logic [DWID-1:0] din,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n,
  output logic [DWID-1:0] dout,
  output logic            oe_n
);

  localparam int VBW = DWID - 3;
  localparam logic [DWID-1:0] OP_ED = 8'hED;
  localparam logic [DWID-1:0] OP_4D = 8'h4D;

  typedef enum logic {R_IDLE, R_ED} reti_state_t;

  // Edge-detect history and interrupt state
  logic [NCH-1:0] zc_q;
  logic [NCH-1:0] zc_rise;
  logic [NCH-1:0] ip;
  logic [NCH-1:0] ip_next;
  logic [NCH-1:0] ius;
  logic [NCH-1:0] ius_next;
  logic [VBW-1:0] vec_base;

  // Bus-cycle decode
  logic inta;
  logic inta_q;
  logic inta_rise;
  logic ack;
  logic fetch;
  logic fetch_q;
  logic byte_stb;
  logic [DWID-1:0] op_lat;

  // Arbitration
  logic [NCH-1:0] ip_low;
  logic [NCH-1:0] ius_low;
  logic [NCH-1:0] ack_oh;
  logic [NCH-1:0] retire_oh;
  logic [1:0]     sel;
  logic           ip_any;
  logic           ius_any;
  logic [DWID-1:0] vector;

  // RETI detector
  reti_state_t state_reg;
  reti_state_t state_next;
  logic        retire;

  assign inta      = !m1_n && !iorq_n;
  assign inta_rise = inta && !inta_q;
  assign fetch     = !m1_n && !rd_n && iorq_n;
  // A fetch ends when RD returns high; the opcode is the byte last seen
  // while the fetch was active.
  assign byte_stb  = fetch_q && rd_n;

  assign ip_any  = |ip;
  assign ius_any = |ius;

  // Lowest set bit isolates the highest-priority channel.
  assign ip_low  = ip  & (~ip  + NCH'(1));
  assign ius_low = ius & (~ius + NCH'(1));

  // Acknowledge only when upstream has granted the chain and something is pending;
  // ip is sampled before this cycle's zc_to edges land.
  assign ack       = inta_rise && iei && ip_any;
  assign ack_oh    = ack ? ip_low : '0;
  // RETI with iei low belongs to a higher-priority device.
  assign retire_oh = (retire && iei) ? ius_low : '0;

  assign vector = {vec_base, sel, 1'b0};

  // Encode the one-hot winner into the channel number used in the vector
  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      if (ip_low[i]) sel = i[1:0];
    end
  end

  // Per-channel next-state for pending and in-service bits
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign zc_rise[gi] = zc_to[gi] && !zc_q[gi];
      // Disable wins; acknowledge clears; an edge on a pending channel is absorbed.
      assign ip_next[gi] = !int_en[gi] ? 1'b0 :
                           ack_oh[gi]  ? 1'b0 :
                           zc_rise[gi] ? 1'b1 : ip[gi];
      // Retire clears first, a same-cycle acknowledge then sets.
      assign ius_next[gi] = ack_oh[gi]    ? 1'b1 :
                            retire_oh[gi] ? 1'b0 : ius[gi];
    end
  endgenerate

  // Register interrupt state and edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zc_q    <= '0;
      ip      <= '0;
      ius     <= '0;
      inta_q  <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      zc_q    <= zc_to;
      ip      <= ip_next;
      ius     <= ius_next;
      inta_q  <= inta;
      fetch_q <= fetch;
    end
  end

  // Vector base write from the CPU; a write mid-acknowledge affects only later vectors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_base <= '0;
    end else if (vec_wstb) begin
      vec_base <= din[DWID-1:3];
    end
  end

  // Track the opcode byte during a fetch so it is available when RD rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_lat <= '0;
    end else if (fetch) begin
      op_lat <= din;
    end
  end

  // Daisy-chain and request outputs, one cycle behind the state they reflect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_n <= 1'b1;
      ieo   <= 1'b0;
    end else begin
      int_n <= !(iei && ip_any && !ius_any);
      ieo   <= iei && !ius_any && !ip_any;
    end
  end

  // Vector drive: latch on the acknowledge edge, hold through INTA, release after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      oe_n <= 1'b1;
    end else if (ack) begin
      dout <= vector;
      oe_n <= 1'b0;
    end else if (!inta) begin
      dout <= '0;
      oe_n <= 1'b1;
    end
  end

  // RETI detector state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= R_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // RETI detector next state; advances only on completed opcode fetches
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    if (byte_stb) begin
      case (state_reg)
        R_IDLE: begin
          state_next = (op_lat == OP_ED) ? R_ED : R_IDLE;
        end
        R_ED: begin
          if (op_lat == OP_4D) begin
            state_next = R_IDLE;
            retire     = 1'b1;
          end else if (op_lat == OP_ED) begin
            state_next = R_ED;
          end else begin
            state_next = R_IDLE;
          end
        end
        default: state_next = R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// tb_ctc_int_ctrl: directed scenarios plus randomized bus traffic checked
// against a behavioural model of the interrupt controller.
module tb_ctc_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] zc_to;
  logic [3:0] int_en;
  logic       vec_wstb;
  logic [7:0] din;
  logic       m1_n;
  logic       iorq_n;
  logic       rd_n;
  logic       iei;
  logic       ieo;
  logic       int_n;
  logic [7:0] dout;
  logic       oe_n;

  int checks = 0;
  int errors = 0;

  ctc_int_ctrl #(.DWID(8), .NCH(4)) dut (
    .clk(clk), .reset(reset), .zc_to(zc_to), .int_en(int_en),
    .vec_wstb(vec_wstb), .din(din), .m1_n(m1_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .iei(iei), .ieo(ieo), .int_n(int_n), .dout(dout), .oe_n(oe_n)
  );

  always #5 clk = ~clk;

  // Behavioural model: expected outputs after each clock edge
  bit       e_int_n = 1'b1;
  bit       e_ieo   = 1'b0;
  bit [7:0] e_dout  = 8'h00;
  bit       e_oe_n  = 1'b1;

  initial begin : model
    bit [3:0] m_ip, m_ius, m_zc_prev, nip, nius;
    bit [4:0] m_vb;
    bit       m_inta_prev, m_fetch_prev, m_after_ed, inta, ack, retire, done;
    bit [7:0] m_op;
    int       ch;
    m_ip = 0; m_ius = 0; m_zc_prev = 0; m_vb = 0; m_inta_prev = 0;
    m_fetch_prev = 0; m_after_ed = 0; m_op = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_ip = 0; m_ius = 0; m_zc_prev = 0; m_vb = 0; m_inta_prev = 0;
        m_fetch_prev = 0; m_after_ed = 0; m_op = 0;
        e_int_n = 1; e_ieo = 0; e_dout = 0; e_oe_n = 1;
      end else begin
        e_int_n = !(iei && (m_ip != 0) && (m_ius == 0));
        e_ieo   = iei && (m_ius == 0) && (m_ip == 0);
        inta = !m1_n && !iorq_n;
        ack  = inta && !m_inta_prev && iei && (m_ip != 0);
        ch = -1;
        for (int i = 0; i < 4; i++) if (ch < 0 && m_ip[i]) ch = i;
        nip = m_ip; nius = m_ius;
        retire = 0;
        if (m_fetch_prev && rd_n) begin
          if (m_after_ed && m_op == 8'h4D) begin
            retire = 1; m_after_ed = 0;
          end else begin
            m_after_ed = (m_op == 8'hED);
          end
        end
        if (retire && iei) begin
          done = 0;
          for (int i = 0; i < 4; i++) if (!done && m_ius[i]) begin nius[i] = 0; done = 1; end
        end
        for (int i = 0; i < 4; i++) begin
          if (!int_en[i]) nip[i] = 0;
          else if (ack && ch == i) nip[i] = 0;
          else if (zc_to[i] && !m_zc_prev[i]) nip[i] = 1;
        end
        if (ack) begin
          nius[ch] = 1;
          e_dout = {m_vb, ch[1:0], 1'b0};
          e_oe_n = 0;
        end else if (!inta) begin
          e_dout = 0; e_oe_n = 1;
        end
        if (vec_wstb) m_vb = din[7:3];
        if (!m1_n && !rd_n && iorq_n) m_op = din;
        m_fetch_prev = !m1_n && !rd_n && iorq_n;
        m_inta_prev  = inta;
        m_zc_prev    = zc_to;
        m_ip  = nip;
        m_ius = nius;
      end
    end
  end

  // Stimulus helpers; all are entered and left on a falling edge
  task automatic pulse_zc(input logic [3:0] m);
    zc_to = m; @(negedge clk); zc_to = 4'b0000;
  endtask

  task automatic write_vec(input logic [7:0] b);
    din = b; vec_wstb = 1'b1; @(negedge clk); vec_wstb = 1'b0;
  endtask

  task automatic fetch_byte(input logic [7:0] b);
    m1_n = 1'b0; rd_n = 1'b0; din = b; @(negedge clk);
    rd_n = 1'b1; m1_n = 1'b1; @(negedge clk);
  endtask

  task automatic reti();
    fetch_byte(8'hED); fetch_byte(8'h4D);
  endtask

  task automatic inta_on();
    m1_n = 1'b0; iorq_n = 1'b0;
  endtask

  task automatic inta_off();
    m1_n = 1'b1; iorq_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; iei = 1'b1; int_en = 4'b0000; zc_to = 4'b0000; vec_wstb = 1'b0;
    din = 8'h00; m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL reset_int_n: got %b want 1", int_n); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", oe_n); end
    checks++; if (ieo !== 1'b0) begin errors++; $display("FAIL reset_ieo: got %b want 0", ieo); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ieo !== 1'b1) begin errors++; $display("FAIL reset_release_ieo: got %b want 1", ieo); end
    $display("test_reset done");
  endtask

  task automatic test_single_channel();
    int_en = 4'b0100;
    write_vec(8'h40);
    pulse_zc(4'b0100);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL single_int_n_early: got %b want 1", int_n); end
    @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL single_int_n: got %b want 0", int_n); end
    checks++; if (ieo !== 1'b0) begin errors++; $display("FAIL single_ieo: got %b want 0", ieo); end
    inta_on(); @(negedge clk);
    checks++; if (dout !== 8'h44) begin errors++; $display("FAIL single_vector: got %h want 44", dout); end
    checks++; if (oe_n !== 1'b0) begin errors++; $display("FAIL single_oe_n: got %b want 0", oe_n); end
    @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL single_int_n_after_ack: got %b want 1", int_n); end
    checks++; if (dout !== 8'h44 || oe_n !== 1'b0) begin errors++; $display("FAIL single_hold: got %h/%b want 44/0", dout, oe_n); end
    inta_off(); @(negedge clk);
    checks++; if (dout !== 8'h00 || oe_n !== 1'b1) begin errors++; $display("FAIL single_release: got %h/%b want 00/1", dout, oe_n); end
    reti(); @(negedge clk);
    checks++; if (ieo !== 1'b1) begin errors++; $display("FAIL single_reti_ieo: got %b want 1", ieo); end
    $display("test_single_channel done");
  endtask

  task automatic test_priority();
    int_en = 4'b1111;
    write_vec(8'h80);
    pulse_zc(4'b1010); @(negedge clk);
    inta_on(); @(negedge clk);
    checks++; if (dout !== 8'h82) begin errors++; $display("FAIL prio_first_vector: got %h want 82", dout); end
    inta_off(); @(negedge clk);
    reti(); @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL prio_reassert: got %b want 0", int_n); end
    inta_on(); @(negedge clk);
    checks++; if (dout !== 8'h86) begin errors++; $display("FAIL prio_second_vector: got %h want 86", dout); end
    inta_off(); @(negedge clk);
    reti(); @(negedge clk);
    checks++; if (ieo !== 1'b1) begin errors++; $display("FAIL prio_clear_ieo: got %b want 1", ieo); end
    $display("test_priority done");
  endtask

  task automatic test_no_nesting();
    pulse_zc(4'b0010); @(negedge clk);
    inta_on(); @(negedge clk); inta_off(); @(negedge clk);
    pulse_zc(4'b0001); repeat (2) @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL nest_int_n: got %b want 1", int_n); end
    checks++; if (ieo !== 1'b0) begin errors++; $display("FAIL nest_ieo: got %b want 0", ieo); end
    reti(); @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL nest_after_reti: got %b want 0", int_n); end
    inta_on(); @(negedge clk);
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL nest_ch0_vector: got %h want 80", dout); end
    inta_off(); @(negedge clk);
    reti(); @(negedge clk);
    $display("test_no_nesting done");
  endtask

  task automatic test_iei_low();
    pulse_zc(4'b0010); @(negedge clk);
    inta_on(); @(negedge clk); inta_off(); @(negedge clk);
    iei = 1'b0;
    pulse_zc(4'b0100); repeat (2) @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL iei_int_n: got %b want 1", int_n); end
    inta_on(); repeat (2) @(negedge clk);
    checks++; if (oe_n !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL iei_no_ack: got %h/%b want 00/1", dout, oe_n); end
    inta_off(); @(negedge clk);
    reti();
    iei = 1'b1; repeat (2) @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL iei_ius_kept: got %b want 1", int_n); end
    reti(); @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL iei_retire_later: got %b want 0", int_n); end
    inta_on(); @(negedge clk);
    checks++; if (dout !== 8'h84) begin errors++; $display("FAIL iei_ch2_vector: got %h want 84", dout); end
    inta_off(); @(negedge clk);
    reti(); @(negedge clk);
    $display("test_iei_low done");
  endtask

  task automatic test_disable_and_seq();
    int_en = 4'b0100;
    pulse_zc(4'b0100); @(negedge clk);
    checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL dis_pending: got %b want 0", int_n); end
    int_en = 4'b0000; repeat (2) @(negedge clk);
    checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL dis_int_n: got %b want 1", int_n); end
    checks++; if (ieo !== 1'b1) begin errors++; $display("FAIL dis_ieo: got %b want 1", ieo); end
    int_en = 4'b0100;
    pulse_zc(4'b0100); @(negedge clk);
    inta_on(); @(negedge clk); inta_off(); @(negedge clk);
    fetch_byte(8'hED); fetch_byte(8'h00); fetch_byte(8'h4D); @(negedge clk);
    checks++; if (ieo !== 1'b0) begin errors++; $display("FAIL seq_ed00_4d: ieo got %b want 0", ieo); end
    fetch_byte(8'hED); fetch_byte(8'hED); fetch_byte(8'h4D); @(negedge clk);
    checks++; if (ieo !== 1'b1) begin errors++; $display("FAIL seq_eded_4d: ieo got %b want 1", ieo); end
    $display("test_disable_and_seq done");
  endtask

  task automatic test_reset_mid_ack();
    int_en = 4'b1111;
    pulse_zc(4'b0001); @(negedge clk);
    inta_on(); @(negedge clk);
    checks++; if (oe_n !== 1'b0) begin errors++; $display("FAIL midack_drive: got %b want 0", oe_n); end
    #2 reset = 1'b1;
    #1;
    checks++; if (oe_n !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL midack_async: got %h/%b want 00/1", dout, oe_n); end
    @(negedge clk);
    reset = 1'b0; inta_off(); @(negedge clk);
    checks++; if (ieo !== 1'b1 || int_n !== 1'b1) begin errors++; $display("FAIL midack_state_lost: ieo/int_n got %b/%b want 1/1", ieo, int_n); end
    $display("test_reset_mid_ack done");
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++; if (int_n !== e_int_n) begin errors++; $display("FAIL rand_int_n cyc %0d: got %b want %b", c, int_n, e_int_n); end
      checks++; if (ieo !== e_ieo) begin errors++; $display("FAIL rand_ieo cyc %0d: got %b want %b", c, ieo, e_ieo); end
      checks++; if (oe_n !== e_oe_n) begin errors++; $display("FAIL rand_oe_n cyc %0d: got %b want %b", c, oe_n, e_oe_n); end
      checks++; if (dout !== e_dout) begin errors++; $display("FAIL rand_dout cyc %0d: got %h want %h", c, dout, e_dout); end
      zc_to    = 4'($urandom);
      int_en   = 4'($urandom | $urandom);
      iei      = ($urandom_range(0, 7) != 0);
      vec_wstb = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 2);
      din = (r == 0) ? 8'hED : (r == 1) ? 8'h4D : 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4) begin m1_n = 1; iorq_n = 1; rd_n = 1; end
      else if (r < 7) begin m1_n = 0; iorq_n = 1; rd_n = 0; end
      else begin m1_n = 0; iorq_n = 0; rd_n = 1; end
    end
    zc_to = 0; vec_wstb = 0; m1_n = 1; iorq_n = 1; rd_n = 1; iei = 1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_priority();
    test_no_nesting();
    test_iei_low();
    test_disable_and_seq();
    test_reset_mid_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
